snoop_bus_arbiter: RTL and testbench

Bus-side transaction engine between the requesting caches' controllers and every `snoop_controller` instance. It accepts one coherence request at a time and broadcasts it to all other caches with a one-cycle `tx_begin`. It collects hit/wait responses, steps the bus address while a modified owner forwards its block, and writes forwarded beats back to memory. When no cache supplies the block, it fetches it from memory, then returns data and the final sharing state to the requester.

---
 rtl/snoop_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Bus-side coherence transaction engine: broadcasts one request to all other caches,
// forwards a modified owner's beats (with write-back) or fetches the block from memory.
module snoop_bus_arbiter #(
   parameter int num_caches_p     = 4,
   parameter int dma_data_width_p = 2,
   parameter int block_size_p     = 8,
   localparam int id_w  = $clog2(num_caches_p),
   // Bus packet is {req_type[1:0], addr[31:0]}; its width does not depend on the beat width.
   localparam int pkt_w = 34,
   localparam int d_w   = dma_data_width_p * 32
) (
   input  logic                         clk_i,
   input  logic                         nreset_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [pkt_w-1:0]             req_pkt_i,
   input  logic [id_w-1:0]              req_id_i,
   output logic [num_caches_p-1:0]      sb_valid_o,
   output logic                         sb_tx_begin_o,
   output logic [num_caches_p-1:0]      sb_last_rx_o,
   output logic [pkt_w-1:0]             sb_bus_pkt_o,
   input  logic [num_caches_p-1:0]      sb_wait_i,
   input  logic [num_caches_p-1:0]      sb_hit_i,
   input  logic [num_caches_p-1:0]      sb_valid_i,
   input  logic [num_caches_p*d_w-1:0]  sb_data_i,
   output logic                         mem_rd_o,
   input  logic                         mem_valid_i,
   input  logic [d_w-1:0]               mem_rdata_i,
   output logic                         mem_wr_o,
   output logic [31:0]                  mem_addr_o,
   output logic [d_w-1:0]               mem_wdata_o,
   output logic                         resp_valid_o,
   output logic                         resp_last_o,
   output logic [d_w-1:0]               resp_data_o,
   output logic                         resp_shared_o,
   output logic [id_w-1:0]              resp_id_o
);

   localparam int beats = block_size_p / dma_data_width_p;
   localparam int cnt_w = $clog2(beats + 1);
   localparam logic [cnt_w-1:0] beats_c      = cnt_w'(beats);
   localparam logic [31:0]      blk_off_mask = 32'(block_size_p * 4 - 1);
   localparam logic [31:0]      beat_bytes   = 32'(dma_data_width_p * 4);
   localparam logic [1:0] op_ld_shared    = 2'd0;
   localparam logic [1:0] op_up_exclusive = 2'd2;

   typedef enum logic [2:0] {s_idle, s_begin, s_snoop, s_wait, s_mem, s_done} state_t;

   state_t            state_q, state_d;
   logic [pkt_w-1:0]  pkt_q, pkt_d;
   logic [id_w-1:0]   id_q, id_d;
   logic [cnt_w-1:0]  beat_cnt_q, beat_cnt_d;
   logic              hit_any_q, hit_any_d;

   logic [num_caches_p-1:0] mask;
   logic [num_caches_p-1:0] fwd_vec;
   logic                    wait_any;
   logic [d_w-1:0]          owner_data;
   logic [cnt_w-1:0]        cnt_inc;
   logic [31:0]             beat_addr;
   logic                    is_upgrade;
   logic                    partial_err;

   assign mask       = ~(num_caches_p'(1) << id_q);
   assign fwd_vec    = sb_valid_i & mask;
   assign wait_any   = |(sb_wait_i & mask);
   assign cnt_inc    = beat_cnt_q + cnt_w'(1);
   assign is_upgrade = (pkt_q[33:32] == op_up_exclusive);
   assign beat_addr  = (pkt_q[31:0] & ~blk_off_mask) + 32'(beat_cnt_q) * beat_bytes;

   // Lowest-index forwarding cache wins the data path.
   always_comb begin
      owner_data = '0;
      for (int i = num_caches_p - 1; i >= 0; i--) begin
         if (fwd_vec[i]) owner_data = sb_data_i[i*d_w +: d_w];
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q    <= s_idle;
         pkt_q      <= '0;
         id_q       <= '0;
         beat_cnt_q <= '0;
         hit_any_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_q      <= pkt_d;
         id_q       <= id_d;
         beat_cnt_q <= beat_cnt_d;
         hit_any_q  <= hit_any_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pkt_d         = pkt_q;
      id_d          = id_q;
      beat_cnt_d    = beat_cnt_q;
      hit_any_d     = hit_any_q;
      req_ready_o   = 1'b0;
      sb_tx_begin_o = 1'b0;
      sb_last_rx_o  = '0;
      mem_rd_o      = 1'b0;
      mem_wr_o      = 1'b0;
      mem_wdata_o   = '0;
      resp_valid_o  = 1'b0;
      resp_last_o   = 1'b0;
      resp_data_o   = '0;
      partial_err   = 1'b0;
      case (state_q)
         s_idle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               pkt_d   = req_pkt_i;
               id_d    = req_id_i;
               state_d = s_begin;
            end
         end
         s_begin: begin
            sb_tx_begin_o = 1'b1;
            state_d       = s_snoop;
         end
         s_snoop: begin
            hit_any_d = |(sb_hit_i & mask);
            if (wait_any)        state_d = s_wait;
            else if (is_upgrade) state_d = s_done;
            else                 state_d = s_mem;
         end
         s_wait: begin
            if (beat_cnt_q == beats_c - cnt_w'(1)) sb_last_rx_o = mask;
            if (|fwd_vec) begin
               resp_valid_o = 1'b1;
               mem_wr_o     = 1'b1;
               resp_data_o  = owner_data;
               mem_wdata_o  = owner_data;
               resp_last_o  = (cnt_inc == beats_c);
               beat_cnt_d   = cnt_inc;
            end
            // A beat arriving in the same cycle the waits drop still counts toward the exit.
            if (!wait_any) begin
               if (beat_cnt_d == beats_c) begin
                  state_d = s_idle;
               end else if (beat_cnt_d == '0) begin
                  state_d = is_upgrade ? s_done : s_mem;
               end else begin
                  state_d     = s_idle;
                  partial_err = 1'b1;
               end
            end
         end
         s_mem: begin
            mem_rd_o = 1'b1;
            if (mem_valid_i) begin
               resp_valid_o = 1'b1;
               resp_data_o  = mem_rdata_i;
               resp_last_o  = (cnt_inc == beats_c);
               beat_cnt_d   = cnt_inc;
               if (cnt_inc == beats_c) state_d = s_idle;
            end
         end
         s_done: begin
            resp_valid_o = 1'b1;
            resp_last_o  = 1'b1;
            state_d      = s_idle;
         end
         default: state_d = s_idle;
      endcase
      if (state_d == s_idle) beat_cnt_d = '0;
   end

   assign sb_valid_o    = (state_q == s_idle) ? '0 : mask;
   assign sb_bus_pkt_o  = {pkt_q[33:32], beat_addr};
   assign mem_addr_o    = beat_addr;
   assign resp_shared_o = resp_valid_o & hit_any_q & (pkt_q[33:32] == op_ld_shared);
   assign resp_id_o     = id_q;

   a_single_owner: assert property (@(posedge clk_i) disable iff (!nreset_i)
      $onehot0(sb_valid_i & mask));
   a_mem_valid_in_mem: assert property (@(posedge clk_i) disable iff (!nreset_i)
      !(mem_valid_i && (state_q != s_mem)));
   a_no_partial_fwd: assert property (@(posedge clk_i) disable iff (!nreset_i)
      !partial_err);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized bench for snoop_bus_arbiter: a per-transaction schedule model sets the
// expected outputs for each cycle and one negedge process compares them with the DUT.
module tb_snoop_bus_arbiter;

   localparam int N      = 4;
   localparam int DW     = 2;
   localparam int BS     = 8;
   localparam int BEATS  = BS / DW;
   localparam int D      = DW * 32;
   localparam int PKT_W  = 34;
   localparam int ID_W   = 2;
   localparam logic [1:0] OP_LD_SHARED = 2'd0;
   localparam logic [1:0] OP_LD_EXCL   = 2'd1;
   localparam logic [1:0] OP_UP_EXCL   = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               nreset;
   logic               req_valid;
   logic               req_ready_o;
   logic [PKT_W-1:0]   req_pkt;
   logic [ID_W-1:0]    req_id;
   logic [N-1:0]       sb_valid_o, sb_last_rx_o;
   logic               sb_tx_begin_o;
   logic [PKT_W-1:0]   sb_bus_pkt_o;
   logic [N-1:0]       sb_wait, sb_hit, sb_valid;
   logic [N*D-1:0]     sb_data;
   logic               mem_rd_o, mem_wr_o;
   logic               mem_valid;
   logic [D-1:0]       mem_rdata;
   logic [31:0]        mem_addr_o;
   logic [D-1:0]       mem_wdata_o;
   logic               resp_valid_o, resp_last_o, resp_shared_o;
   logic [D-1:0]       resp_data_o;
   logic [ID_W-1:0]    resp_id_o;

   snoop_bus_arbiter #(.num_caches_p(N), .dma_data_width_p(DW), .block_size_p(BS)) dut (
      .clk_i(clk), .nreset_i(nreset),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_pkt_i(req_pkt), .req_id_i(req_id),
      .sb_valid_o(sb_valid_o), .sb_tx_begin_o(sb_tx_begin_o), .sb_last_rx_o(sb_last_rx_o),
      .sb_bus_pkt_o(sb_bus_pkt_o), .sb_wait_i(sb_wait), .sb_hit_i(sb_hit), .sb_valid_i(sb_valid),
      .sb_data_i(sb_data), .mem_rd_o(mem_rd_o), .mem_valid_i(mem_valid), .mem_rdata_i(mem_rdata),
      .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .resp_valid_o(resp_valid_o), .resp_last_o(resp_last_o), .resp_data_o(resp_data_o),
      .resp_shared_o(resp_shared_o), .resp_id_o(resp_id_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Expected values for the current cycle
   logic          chk_en = 1'b0;
   logic          e_ready, e_txb, e_mem_rd, e_mem_wr, e_rv, e_rl, e_rs, e_rst, e_active;
   logic [N-1:0]  e_sbv, e_lrx;
   logic [31:0]   e_addr;
   logic [1:0]    e_type;
   logic [D-1:0]  e_rdata, e_wdata;
   logic [ID_W-1:0] e_id;

   logic [31:0] cap_addr[$];
   logic        cap_last[$];
   logic [N-1:0] cap_lrx[$];
   logic [D-1:0] cap_data[$];
   logic        cap_sh[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 64'(req_ready_o), 64'(e_ready));
         check("sb_valid", 64'(sb_valid_o), 64'(e_sbv));
         check("tx_begin", 64'(sb_tx_begin_o), 64'(e_txb));
         check("last_rx", 64'(sb_last_rx_o), 64'(e_lrx));
         check("mem_rd", 64'(mem_rd_o), 64'(e_mem_rd));
         check("mem_wr", 64'(mem_wr_o), 64'(e_mem_wr));
         check("resp_valid", 64'(resp_valid_o), 64'(e_rv));
         check("resp_last", 64'(resp_last_o), 64'(e_rl));
         if (e_rst) begin
            check("rst_bus_pkt", 64'(sb_bus_pkt_o), 64'd0);
            check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
            check("rst_resp_data", 64'(resp_data_o), 64'd0);
            check("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
            check("rst_resp_id", 64'(resp_id_o), 64'd0);
            check("rst_resp_shared", 64'(resp_shared_o), 64'd0);
         end
         if (e_active) begin
            check("bus_addr", 64'(sb_bus_pkt_o[31:0]), 64'(e_addr));
            check("bus_type", 64'(sb_bus_pkt_o[33:32]), 64'(e_type));
         end
         if (e_mem_rd || e_mem_wr) check("mem_addr", 64'(mem_addr_o), 64'(e_addr));
         if (e_mem_wr) check("mem_wdata", 64'(mem_wdata_o), 64'(e_wdata));
         if (e_rv) begin
            check("resp_data", 64'(resp_data_o), 64'(e_rdata));
            check("resp_shared", 64'(resp_shared_o), 64'(e_rs));
            check("resp_id", 64'(resp_id_o), 64'(e_id));
         end
         if (resp_valid_o === 1'b1) begin
            cap_addr.push_back(mem_addr_o);
            cap_last.push_back(resp_last_o);
            cap_lrx.push_back(sb_last_rx_o);
            cap_data.push_back(resp_data_o);
            cap_sh.push_back(resp_shared_o);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      cap_addr.delete(); cap_last.delete(); cap_lrx.delete(); cap_data.delete(); cap_sh.delete();
   endtask

   // Background inputs: junk data, random hits, and wait/valid noise only on the requester bit.
   task automatic drive_quiet(input bit busy, input int nid);
      req_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      req_pkt   = {2'($urandom_range(0, 3)), 32'($urandom)};
      req_id    = ID_W'($urandom_range(0, N - 1));
      sb_hit    = N'($urandom);
      sb_wait   = N'($urandom_range(0, 1)) << nid;
      sb_valid  = N'($urandom_range(0, 1)) << nid;
      for (int w = 0; w < N * D / 32; w++) sb_data[w*32 +: 32] = $urandom;
      mem_valid = 1'b0;
      mem_rdata = {$urandom, $urandom};
   endtask

   task automatic exp_clear();
      e_ready = 0; e_txb = 0; e_mem_rd = 0; e_mem_wr = 0; e_rv = 0; e_rl = 0; e_rs = 0;
      e_rst = 0; e_active = 0; e_sbv = '0; e_lrx = '0; e_addr = '0; e_type = '0;
      e_rdata = '0; e_wdata = '0; e_id = '0;
   endtask

   task automatic exp_idle();
      exp_clear();
      e_ready = 1'b1;
   endtask

   task automatic exp_reset();
      exp_idle();
      e_rst = 1'b1;
   endtask

   task automatic exp_busy(input logic [N-1:0] mask, input logic [31:0] addr, input logic [1:0] typ);
      exp_clear();
      e_sbv = mask; e_active = 1'b1; e_addr = addr; e_type = typ;
   endtask

   // One full transaction from the bus point of view; rst_beat>0 pulls reset on that forwarded beat.
   task automatic run_txn(input int id, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [N-1:0] hitv, input logic [N-1:0] waitv, input bit fwd,
                          input int holds, input int rst_beat);
      logic [N-1:0] mask;
      logic [31:0]  base;
      logic         shared;
      logic [D-1:0] slice;
      int r, owner, guard, holds_left;
      mask   = ~(4'b0001 << id);
      base   = addr & ~32'(BS * 4 - 1);
      shared = (|(hitv & mask)) && (typ == OP_LD_SHARED);
      owner  = 0;
      for (int i = N - 1; i >= 0; i--) if (waitv[i] && i != id) owner = i;
      r = 0; guard = 0; holds_left = holds;

      repeat ($urandom_range(0, 2)) begin
         step(); drive_quiet(0, id); exp_idle();
      end
      step(); drive_quiet(0, id);
      req_valid = 1'b1; req_pkt = {typ, addr}; req_id = ID_W'(id);
      exp_idle();
      step(); drive_quiet(1, id); exp_busy(mask, base, typ); e_txb = 1'b1;
      step(); drive_quiet(1, id); exp_busy(mask, base, typ);
      sb_hit  = hitv | (N'($urandom_range(0, 1)) << id);
      sb_wait = sb_wait | waitv;

      if ((waitv & mask) != '0) begin
         while (1) begin
            step(); drive_quiet(1, id);
            exp_busy(mask, base + 32'(r * DW * 4), typ);
            e_lrx = (r == BEATS - 1) ? mask : '0;
            if (fwd && r < BEATS) begin
               sb_wait = sb_wait | waitv;
               if ($urandom_range(0, 2) != 0 || guard > 6) begin
                  if (r + 1 == rst_beat) begin
                     nreset = 1'b0;
                     sb_valid = sb_valid | (4'b0001 << owner);
                     exp_reset();
                     step(); drive_quiet(0, id); exp_reset();
                     step(); drive_quiet(0, id); nreset = 1'b1; exp_reset();
                     return;
                  end
                  sb_valid = sb_valid | (4'b0001 << owner);
                  slice = sb_data[owner*D +: D];
                  e_rv = 1'b1; e_mem_wr = 1'b1; e_rdata = slice; e_wdata = slice;
                  e_rl = (r + 1 == BEATS); e_rs = shared; e_id = ID_W'(id);
                  r++; guard = 0;
               end else begin
                  guard++;
               end
            end else if (holds_left > 0) begin
               sb_wait = sb_wait | waitv;
               holds_left--;
            end else begin
               break;
            end
         end
      end

      if (r != BEATS) begin
         if (typ == OP_UP_EXCL) begin
            step(); drive_quiet(1, id); exp_busy(mask, base, typ);
            e_rv = 1'b1; e_rl = 1'b1; e_rdata = '0; e_rs = shared; e_id = ID_W'(id);
         end else begin
            guard = 0;
            while (r < BEATS) begin
               step(); drive_quiet(1, id);
               exp_busy(mask, base + 32'(r * DW * 4), typ);
               e_mem_rd = 1'b1;
               if ($urandom_range(0, 1) == 1 || guard > 6) begin
                  mem_valid = 1'b1;
                  e_rv = 1'b1; e_rdata = mem_rdata; e_rl = (r + 1 == BEATS);
                  e_rs = shared; e_id = ID_W'(id);
                  r++; guard = 0;
               end else begin
                  guard++;
               end
            end
         end
      end
      step(); drive_quiet(0, id); exp_idle();
   endtask

   logic [31:0] lit_a[4] = '{32'h100, 32'h108, 32'h110, 32'h118};

   initial begin
      int id, wc;
      logic [1:0] typ;
      logic [N-1:0] waitv;
      nreset = 1'b0;
      drive_quiet(0, 0);
      exp_reset();
      step();
      chk_en = 1'b1;
      repeat (2) begin step(); drive_quiet(0, 0); exp_reset(); end
      nreset = 1'b1;
      step(); drive_quiet(0, 0); exp_reset();

      // Memory fetch, no hits
      clear_caps();
      run_txn(0, OP_LD_SHARED, 32'h100, 4'b0000, 4'b0000, 0, 0, 0);
      check("lit_mem_beats", 64'(cap_addr.size()), 64'd4);
      for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
         check("lit_mem_addr", 64'(cap_addr[i]), 64'(lit_a[i]));
         check("lit_mem_last", 64'(cap_last[i]), (i == 3) ? 64'd1 : 64'd0);
         check("lit_mem_shared", 64'(cap_sh[i]), 64'd0);
      end

      // Modified owner forwards
      clear_caps();
      run_txn(1, OP_LD_EXCL, 32'h240, 4'b0100, 4'b0100, 1, 2, 0);
      check("lit_fwd_beats", 64'(cap_addr.size()), 64'd4);
      if (cap_addr.size() == 4) begin
         check("lit_fwd_addr0", 64'(cap_addr[0]), 64'h240);
         check("lit_fwd_lrx3", 64'(cap_lrx[3]), 64'b1101);
         check("lit_fwd_lrx2", 64'(cap_lrx[2]), 64'b0000);
      end

      // Shared hits, memory supplies
      clear_caps();
      run_txn(1, OP_LD_SHARED, 32'h3c4, 4'b1001, 4'b0000, 0, 0, 0);
      check("lit_sh_beats", 64'(cap_addr.size()), 64'd4);
      if (cap_addr.size() > 0) check("lit_sh_addr0", 64'(cap_addr[0]), 64'h3c0);
      for (int i = 0; i < cap_sh.size(); i++) check("lit_sh_shared", 64'(cap_sh[i]), 64'd1);

      // Upgrade with a waiter that sends nothing
      clear_caps();
      run_txn(2, OP_UP_EXCL, 32'h500, 4'b0000, 4'b1000, 0, 3, 0);
      check("lit_up_beats", 64'(cap_data.size()), 64'd1);
      if (cap_data.size() == 1) begin
         check("lit_up_data", 64'(cap_data[0]), 64'd0);
         check("lit_up_last", 64'(cap_last[0]), 64'd1);
      end

      // Reset during the 2nd forwarded beat, then a normal request
      run_txn(2, OP_LD_EXCL, 32'h780, 4'b0001, 4'b0001, 1, 1, 2);
      clear_caps();
      run_txn(3, OP_LD_SHARED, 32'h9a0, 4'b0010, 4'b0000, 0, 0, 0);
      check("lit_post_rst_beats", 64'(cap_addr.size()), 64'd4);

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         id  = $urandom_range(0, N - 1);
         typ = 2'($urandom_range(0, 2));
         waitv = '0;
         if ($urandom_range(0, 1) == 1) begin
            wc = $urandom_range(0, N - 1);
            if (wc == id) wc = (wc + 1) % N;
            waitv = N'(1) << wc;
         end
         run_txn(id, typ, $urandom, N'($urandom), waitv, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 0);
      end

      step();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
